// File: rtl/fix_pkg.sv
// Constants, state encoding and helpers shared by the FIX checksum
// generator (transmit side) and checker (receive side).
package fix_pkg;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_1     = 8'h31;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_EQ    = 8'h3D;
  localparam logic [7:0] SOH_DEFAULT = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BODY,
    ST_SOH_SEEN,
    ST_TAG1,
    ST_TAG0,
    ST_DIG,
    ST_FAIL
  } chk_state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

endpackage

// File: rtl/fix_checksum_check.sv
// Receive-side FIX checksum verifier: sums bytes up to the SOH before "10=",
// parses the three trailer digits and reports pass / mismatch / format error.
module fix_checksum_check
  import fix_pkg::*;
#(
  parameter logic [7:0] SOH = SOH_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  input  logic       sop_i,
  input  logic       eop_i,
  output logic       done_o,
  output logic       ok_o,
  output logic       fmt_err_o,
  output logic [7:0] calc_o,
  output logic [9:0] recv_o
);

  chk_state_t state;
  logic [7:0] sum, snap;
  logic [9:0] val;
  logic [1:0] digits;

  logic       is_soh, dig_ok;
  logic [7:0] sum_nxt, snap_nxt, dig;
  logic [9:0] val_nxt;

  always_comb begin
    is_soh   = (data_i == SOH);
    dig_ok   = is_digit(data_i);
    sum_nxt  = sum + data_i;
    snap_nxt = is_soh ? sum_nxt : snap;
    dig      = data_i - ASCII_0;
    // val*10 as (val<<3)+(val<<1); val never exceeds 99 before a third digit
    val_nxt  = {val[6:0], 3'b000} + {val[8:0], 1'b0} + {6'd0, dig[3:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sum       <= '0;
      snap      <= '0;
      val       <= '0;
      digits    <= '0;
      done_o    <= 1'b0;
      ok_o      <= 1'b0;
      fmt_err_o <= 1'b0;
      calc_o    <= '0;
      recv_o    <= '0;
    end else begin
      done_o <= 1'b0;
      if (valid_i && sop_i) begin
        sum    <= data_i;
        snap   <= is_soh ? data_i : 8'h00;
        val    <= '0;
        digits <= '0;
        state  <= is_soh ? ST_SOH_SEEN : ST_BODY;
        if (eop_i) begin
          done_o    <= 1'b1;
          ok_o      <= 1'b0;
          fmt_err_o <= 1'b1;
          calc_o    <= is_soh ? data_i : 8'h00;
          recv_o    <= '0;
          state     <= ST_IDLE;
        end
      end else if (valid_i && state != ST_IDLE) begin
        if (state != ST_DIG && state != ST_FAIL) begin
          sum <= sum_nxt;
          if (is_soh) snap <= sum_nxt;
        end
        case (state)
          ST_BODY:     state <= is_soh ? ST_SOH_SEEN : ST_BODY;
          ST_SOH_SEEN: state <= (data_i == ASCII_1) ? ST_TAG1 :
                                is_soh ? ST_SOH_SEEN : ST_BODY;
          ST_TAG1:     state <= (data_i == ASCII_0) ? ST_TAG0 :
                                is_soh ? ST_SOH_SEEN : ST_BODY;
          ST_TAG0:     state <= (data_i == ASCII_EQ) ? ST_DIG :
                                is_soh ? ST_SOH_SEEN : ST_BODY;
          ST_DIG: begin
            if (dig_ok && digits != 2'd3) begin
              val    <= val_nxt;
              digits <= digits + 2'd1;
            end else if (!is_soh) begin
              state <= ST_FAIL;
            end
          end
          default: state <= ST_FAIL;
        endcase
        if (eop_i) begin
          done_o <= 1'b1;
          recv_o <= val;
          state  <= ST_IDLE;
          if (state == ST_DIG && is_soh && digits == 2'd3) begin
            ok_o      <= (val == {2'b00, snap});
            fmt_err_o <= 1'b0;
            calc_o    <= snap;
          end else begin
            ok_o      <= 1'b0;
            fmt_err_o <= 1'b1;
            calc_o    <= (state == ST_DIG || state == ST_FAIL) ? snap : snap_nxt;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fix_checksum_check.sv
// Directed-vector bench for fix_checksum_check; expected verdicts are queued
// at stimulus time and popped by a monitor whenever done_o pulses.
module tb_fix_checksum_check;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_i;
  logic       valid_i, sop_i, eop_i;
  logic       done_o, ok_o, fmt_err_o;
  logic [7:0] calc_o;
  logic [9:0] recv_o;

  fix_checksum_check dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
    .sop_i(sop_i), .eop_i(eop_i), .done_o(done_o), .ok_o(ok_o),
    .fmt_err_o(fmt_err_o), .calc_o(calc_o), .recv_o(recv_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ok;
    logic       fmt;
    logic [7:0] calc;
    logic [9:0] recv;
    logic       full;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0, n_fail = 0;
  int   n_done = 0, n_pushed = 0;

  task automatic expect_v(input string name, input logic ok, input logic fmt,
                          input logic [7:0] calc, input logic [9:0] recv,
                          input logic full);
    exp_t e;
    e.name = name; e.ok = ok; e.fmt = fmt; e.calc = calc; e.recv = recv; e.full = full;
    sb.push_back(e);
    n_pushed++;
  endtask

  // Called with time just after a posedge; '|' in the string stands for SOH.
  task automatic send_msg(input string s, input bit with_eop, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] c;
      c = s[i];
      if (c == 8'h7C) c = 8'h01;
      if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      data_i  = c;
      valid_i = 1'b1;
      sop_i   = (i == 0);
      eop_i   = with_eop && (i == s.len() - 1);
      @(posedge clk); #1;
      valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0; data_i = 8'h00;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done_o) begin
      exp_t e;
      n_done++;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got ok=%0b fmt=%0b calc=%0d recv=%0d, none expected",
                 ok_o, fmt_err_o, calc_o, recv_o);
      end else begin
        e = sb.pop_front();
        if (ok_o !== e.ok || fmt_err_o !== e.fmt ||
            (e.full && (calc_o !== e.calc || recv_o !== e.recv))) begin
          n_fail++;
          $display("FAIL %s: got ok=%0b fmt=%0b calc=%0d recv=%0d, want ok=%0b fmt=%0b calc=%0d recv=%0d",
                   e.name, ok_o, fmt_err_o, calc_o, recv_o, e.ok, e.fmt, e.calc, e.recv);
        end
      end
    end
  end

  task automatic check_idle_outputs(input string name);
    n_tests++;
    if (done_o !== 1'b0 || ok_o !== 1'b0 || fmt_err_o !== 1'b0 ||
        calc_o !== 8'd0 || recv_o !== 10'd0) begin
      n_fail++;
      $display("FAIL %s: got done=%0b ok=%0b fmt=%0b calc=%0d recv=%0d, want all 0",
               name, done_o, ok_o, fmt_err_o, calc_o, recv_o);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0; data_i = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_idle_outputs("reset_state");

    for (int pass = 0; pass < 2; pass++) begin
      bit g;
      g = (pass == 1);
      expect_v("good_183", 1'b1, 1'b0, 8'd183, 10'd183, 1'b1);
      send_msg("8=A|10=183|", 1'b1, g);
      if (!g) begin
        repeat (4) @(posedge clk); #1;
        n_tests++;
        if (ok_o !== 1'b1 || done_o !== 1'b0 || calc_o !== 8'd183) begin
          n_fail++;
          $display("FAIL output_hold: got ok=%0b done=%0b calc=%0d, want ok=1 done=0 calc=183",
                   ok_o, done_o, calc_o);
        end
      end
      expect_v("mismatch_184", 1'b0, 1'b0, 8'd183, 10'd184, 1'b1);
      send_msg("8=A|10=184|", 1'b1, g);
      expect_v("wrap_060", 1'b1, 1'b0, 8'd60, 10'd60, 1'b1);
      send_msg("8=ABC|10=060|", 1'b1, g);
      expect_v("decoy_110", 1'b1, 1'b0, 8'd184, 10'd184, 1'b1);
      send_msg("8=A|110=1|10=184|", 1'b1, g);
      expect_v("fmt_nondigit", 1'b0, 1'b1, 8'd183, 10'd18, 1'b1);
      send_msg("8=A|10=18A|", 1'b1, g);
    end

    expect_v("fmt_4digits", 1'b0, 1'b1, 8'd183, 10'd183, 1'b1);
    send_msg("8=A|10=1834|", 1'b1, 1'b0);
    expect_v("fmt_2digits", 1'b0, 1'b1, 8'd183, 10'd18, 1'b1);
    send_msg("8=A|10=18|", 1'b1, 1'b0);
    expect_v("fmt_no_trailer", 1'b0, 1'b1, 8'd183, 10'd0, 1'b1);
    send_msg("8=A|", 1'b1, 1'b0);
    expect_v("single_byte", 1'b0, 1'b1, 8'd0, 10'd0, 1'b0);
    send_msg("A", 1'b1, 1'b0);

    // Aborted message: restart via sop, only the second message reports
    send_msg("8=A|10=1", 1'b0, 1'b0);
    expect_v("after_sop_abort", 1'b1, 1'b0, 8'd183, 10'd183, 1'b1);
    send_msg("8=A|10=183|", 1'b1, 1'b0);

    // Mid-body reset: outputs clear, partial message is dropped
    repeat (3) @(posedge clk); #1;
    send_msg("8=AB", 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    check_idle_outputs("reset_mid_body");
    expect_v("after_reset", 1'b1, 1'b0, 8'd60, 10'd60, 1'b1);
    send_msg("8=ABC|10=060|", 1'b1, 1'b0);

    for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
    repeat (3) @(posedge clk); #1;
    n_tests++;
    if (sb.size() != 0 || n_done != n_pushed) begin
      n_fail++;
      $display("FAIL verdict_count: got %0d done pulses (%0d pending), want %0d",
               n_done, sb.size(), n_pushed);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
